// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares the single on-chip memory bus (SPRAM banks + ROM mux) between two
//   masters. M0 is the core and wins by default (its gnt=0 is the core stall).
//   M1 is the debug/DMA loader: it wins a contested cycle once it has been
//   refused MAX_STARVE consecutive cycles. Either master can hold the bus
//   across cycles with its lock input (read-modify-write).
//
// Ports
//   clock, reset            system clock, asynchronous active-low reset
//   mX_req/we/addr/wdata/mask/lock   master X request and bus cycle fields
//   mX_gnt                  combinational grant (request accepted this cycle)
//   mX_rdata/mX_rvalid      read return, one cycle after the read grant
//   mem_select              bus cycle active
//   mem_not_writing         1 = read or idle, 0 = write
//   mem_addr/wdata/mask     bus cycle fields of the granted master (0 if idle)
//   mem_rdata               registered memory output, valid one cycle after read
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_mask,
    input  logic                m0_lock,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_mask,
    input  logic                m1_lock,
    output logic                m0_gnt,
    output logic                m1_gnt,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m0_rvalid,
    output logic                m1_rvalid,
    output logic                mem_select,
    output logic                mem_not_writing,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_mask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;
    localparam logic [7:0] STARVE_MAX = 8'(MAX_STARVE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t            state_r;
    logic [7:0]        starve_cnt_r;
    logic              rvalid0_r;
    logic              rvalid1_r;
    logic              gnt0_s;
    logic              gnt1_s;
    logic              sel_s;
    logic              not_wr_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [MASK_W-1:0] mask_s;

    // Grant decision: fixed priority to M0 unless M1 has starved; a lock
    // restricts the bus to its owner. Nothing is granted while in reset.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (m0_req && m1_req) begin
                        if (starve_cnt_r == STARVE_MAX) begin
                            gnt1_s = 1'b1;
                        end else begin
                            gnt0_s = 1'b1;
                        end
                    end else begin
                        gnt0_s = m0_req;
                        gnt1_s = m1_req;
                    end
                end
                ST_LOCK0: gnt0_s = m0_req;
                ST_LOCK1: gnt1_s = m1_req;
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // Bus mux: the granted master drives the memory bus; idle bus is all zero.
    always_comb begin
        sel_s    = 1'b0;
        not_wr_s = 1'b1;
        addr_s   = '0;
        wdata_s  = '0;
        mask_s   = '0;
        if (gnt1_s) begin
            sel_s    = 1'b1;
            not_wr_s = ~m1_we;
            addr_s   = m1_addr;
            wdata_s  = m1_wdata;
            mask_s   = m1_mask;
        end else if (gnt0_s) begin
            sel_s    = 1'b1;
            not_wr_s = ~m0_we;
            addr_s   = m0_addr;
            wdata_s  = m0_wdata;
            mask_s   = m0_mask;
        end else begin
            sel_s    = 1'b0;
            not_wr_s = 1'b1;
        end
    end

    // Lock FSM, starvation counter and read-return owner flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            starve_cnt_r <= 8'd0;
            rvalid0_r    <= 1'b0;
            rvalid1_r    <= 1'b0;
        end else begin
            // The owner flags act as rd_owner: at most one is set per cycle.
            rvalid0_r <= gnt0_s & ~m0_we;
            rvalid1_r <= gnt1_s & ~m1_we;

            case (state_r)
                ST_IDLE: begin
                    if (gnt0_s && m0_lock) begin
                        state_r <= ST_LOCK0;
                    end else if (gnt1_s && m1_lock) begin
                        state_r <= ST_LOCK1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                // While locked the owner is always granted when requesting,
                // so staying locked only needs req and lock both high.
                ST_LOCK0: begin
                    if (m0_req && m0_lock) begin
                        state_r <= ST_LOCK0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCK1: begin
                    if (m1_req && m1_lock) begin
                        state_r <= ST_LOCK1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase

            // A core-held lock must not count against M1's fairness budget.
            if (state_r == ST_LOCK0) begin
                starve_cnt_r <= starve_cnt_r;
            end else if (!m1_req || gnt1_s) begin
                starve_cnt_r <= 8'd0;
            end else if (starve_cnt_r < STARVE_MAX) begin
                starve_cnt_r <= starve_cnt_r + 8'd1;
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end
    end

    assign m0_gnt          = gnt0_s;
    assign m1_gnt          = gnt1_s;
    assign m0_rvalid       = rvalid0_r;
    assign m1_rvalid       = rvalid1_r;
    // Memory output is already registered, so it is steered, not re-registered.
    assign m0_rdata        = rvalid0_r ? mem_rdata : '0;
    assign m1_rdata        = rvalid1_r ? mem_rdata : '0;
    assign mem_select      = sel_s;
    assign mem_not_writing = not_wr_s;
    assign mem_addr        = addr_s;
    assign mem_wdata       = wdata_s;
    assign mem_mask        = mask_s;

endmodule
